corescore_stream_arbiter: RTL
=============================

Name: corescore_stream_arbiter

Overview:
- Packet-granular round-robin arbiter that shares one byte-wide AXI-stream sink between NUM_SOURCES stream producers.
- Typical sink is the UART emitter; typical producers are core-result streams.
- A grant is held from the first beat until the tlast beat is accepted, so packets never interleave.
- A registered output slice isolates the sink's tready timing from the sources.

Parameters:
- NUM_SOURCES, 4, number of requesting streams (2..16).
- DATA_WIDTH, 8, tdata width per source.
- IDX_W, $clog2(NUM_SOURCES), width of the grant index (derived; not overridden).

Ports:
- i_clk  input  1  clock.
- i_rst  input  1  synchronous active-high reset.
- i_tdata  input  NUM_SOURCES*DATA_WIDTH  source data, source k at bits [k*DATA_WIDTH +: DATA_WIDTH].
- i_tlast  input  NUM_SOURCES  per-source last-beat flag.
- i_tvalid  input  NUM_SOURCES  per-source valid.
- o_tready  output  NUM_SOURCES  per-source ready; at most one bit set.
- o_tdata  output  DATA_WIDTH  registered output data.
- o_tlast  output  1  registered output last.
- o_tvalid  output  1  registered output valid.
- i_tready  input  1  sink ready.
- o_grant  output  IDX_W  index of the current or most recent grant.
- o_busy  output  1  high while in the STREAM state.

Behaviour:
- Interface rule: one clock (i_clk); reset i_rst is synchronous and active-high.
- Reset values:
  - state = IDLE; o_tvalid = 0, o_tlast = 0, o_tdata = 0.
  - o_tready = 0; o_busy = 0.
  - RR pointer = NUM_SOURCES-1, so source 0 wins first; o_grant = NUM_SOURCES-1.
- State IDLE:
  - If any i_tvalid bit is set, pick the first set bit scanning pointer+1, pointer+2, ... modulo NUM_SOURCES.
  - At the clock edge: register the pick into o_grant and the pointer, and go to STREAM.
  - With no requests, stay in IDLE.
- State STREAM:
  - o_tready[o_grant] = slice_free, where slice_free = ~o_tvalid | i_tready. All other o_tready bits are 0.
  - Beat accept = i_tvalid[o_grant] & o_tready[o_grant]. On accept, the slice loads tdata/tlast from the granted source and o_tvalid is set.
  - On accepting a beat with tlast = 1, go to IDLE at the same edge.
- Output slice:
  - If i_tready & o_tvalid and no new beat is loaded, o_tvalid clears.
  - Full throughput: one beat per cycle while the sink holds i_tready high.
- Latency:
  - Requests first seen in IDLE at cycle 0 → o_tready high in cycle 1 → first o_tvalid in cycle 2.
  - Exactly one bubble cycle (the IDLE arbitration cycle) between back-to-back packets.
- Boundary conditions:
  - Granted source drops tvalid mid-packet: the grant is held indefinitely, with no timeout and no re-arbitration.
  - Other sources requesting during STREAM are ignored until IDLE.
  - Single requester: it is re-granted after every packet, with one bubble between packets.
  - Pointer wrap: a grant to NUM_SOURCES-1 gives next priority to source 0.
  - Sink stalls (i_tready = 0) with the slice full: o_tready = 0 and the output holds stable (AXI rule: o_tdata/o_tlast are unchanged while o_tvalid & ~i_tready).
  - Reset mid-packet: the in-flight beat is discarded and all state returns to reset values at the next edge.
  - The downstream sink sees a truncated packet after a mid-packet reset; this is accepted.
  - One-beat packet (tlast on the first beat): STREAM lasts one accept cycle.

Decomposition:
- Shared package corescore_arb_pkg holds:
  - the state enum (IDLE = 1'b0, STREAM = 1'b1);
  - a localparam function clog2-safe IDX_W helper.
- One sub-module is natural: corescore_rr_picker.
  - Purely combinational.
  - Inputs: request vector and pointer.
  - Outputs: one-hot pick, index, and any_req.
- The slice and FSM stay in the top.

Test Plan:
- Reset, then source 2 sends 3 bytes 0x41,0x42,0x43 (tlast on 0x43), sink always ready → o_tready[2] in cycle 1; output beats in cycles 2-4 with tlast only on 0x43; o_busy falls after cycle 3.
- All 4 sources continuously send 2-byte packets → grant order 0,1,2,3,0; exactly one idle cycle between packets; no interleaving.
- Source 1 mid-packet with sink i_tready = 0 for 5 cycles → o_tdata/o_tlast stable; o_tready[1] = 0 while the slice is full; no beat lost or duplicated afterwards.
- Source 0 drops tvalid for 4 cycles mid-packet while source 3 requests → grant stays at 0; source 3 is served only after source 0's tlast.
- i_rst asserted during the 2nd beat of a 4-beat packet → next cycle o_tvalid = 0, o_tready = 0, o_grant = NUM_SOURCES-1; the next arbitration grants source 0 first.
- NUM_SOURCES = 3 with only source 2 requesting, then sources 0 and 2 → wrap-around picks 0 after 2; 1-beat packets each take one STREAM cycle.

Source files
------------

// File: rtl/corescore_arb_pkg.sv
// Shared types and helpers for the packet-granular stream arbiter.
package corescore_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } arb_state_e;

  // Index width that never collapses to zero bits.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/corescore_rr_picker.sv
// Combinational round-robin picker: first requester after ptr, modulo NUM_SOURCES.
module corescore_rr_picker
  import corescore_arb_pkg::*;
#(
  parameter int unsigned NUM_SOURCES = 4,
  parameter int unsigned IDX_W       = idx_width(NUM_SOURCES)
) (
  input  logic [NUM_SOURCES-1:0] req,
  input  logic [IDX_W-1:0]       ptr,
  output logic [NUM_SOURCES-1:0] pick_oh_c,
  output logic [IDX_W-1:0]       pick_idx_c,
  output logic                   any_req_c
);

  int unsigned dist_c;
  int unsigned best_c;

  // Distance of source j from ptr+1 in rotation order; smallest requesting distance wins.
  always_comb begin
    dist_c     = 0;
    best_c     = NUM_SOURCES;
    pick_idx_c = '0;
    pick_oh_c  = '0;
    any_req_c  = |req;
    for (int unsigned j = 0; j < NUM_SOURCES; j++) begin
      dist_c = (j + 2 * NUM_SOURCES - 32'(ptr) - 1) % NUM_SOURCES;
      if (req[j] && (dist_c < best_c)) begin
        best_c     = dist_c;
        pick_idx_c = IDX_W'(j);
      end
    end
    for (int unsigned j = 0; j < NUM_SOURCES; j++) begin
      pick_oh_c[j] = any_req_c && (pick_idx_c == IDX_W'(j));
    end
  end

endmodule

// File: rtl/corescore_stream_arbiter.sv
// Packet-granular round-robin arbiter sharing one AXI-stream sink among NUM_SOURCES
// producers, with a registered output slice in front of the sink.
module corescore_stream_arbiter
  import corescore_arb_pkg::*;
#(
  parameter int unsigned NUM_SOURCES = 4,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned IDX_W       = idx_width(NUM_SOURCES)
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic [NUM_SOURCES*DATA_WIDTH-1:0] i_tdata,
  input  logic [NUM_SOURCES-1:0]            i_tlast,
  input  logic [NUM_SOURCES-1:0]            i_tvalid,
  output logic [NUM_SOURCES-1:0]            o_tready,
  output logic [DATA_WIDTH-1:0]             o_tdata,
  output logic                              o_tlast,
  output logic                              o_tvalid,
  input  logic                              i_tready,
  output logic [IDX_W-1:0]                  o_grant,
  output logic                              o_busy
);

  arb_state_e             state_q, state_d;
  logic [IDX_W-1:0]       grant_q, grant_d;
  logic [NUM_SOURCES-1:0] grant_oh_q, grant_oh_d;
  logic                   tvalid_q, tvalid_d;
  logic                   tlast_q, tlast_d;
  logic [DATA_WIDTH-1:0]  tdata_q, tdata_d;

  logic [NUM_SOURCES-1:0] pick_oh_c;
  logic [IDX_W-1:0]       pick_idx_c;
  logic                   any_req_c;
  logic                   slice_free_c;
  logic                   sel_valid_c;
  logic                   sel_last_c;
  logic [DATA_WIDTH-1:0]  sel_data_c;

  // The current grant doubles as the round-robin pointer.
  corescore_rr_picker #(
    .NUM_SOURCES(NUM_SOURCES),
    .IDX_W      (IDX_W)
  ) u_picker (
    .req       (i_tvalid),
    .ptr       (grant_q),
    .pick_oh_c (pick_oh_c),
    .pick_idx_c(pick_idx_c),
    .any_req_c (any_req_c)
  );

  always_comb begin
    slice_free_c = ~tvalid_q | i_tready;
    sel_valid_c  = 1'b0;
    sel_last_c   = 1'b0;
    sel_data_c   = '0;
    for (int unsigned k = 0; k < NUM_SOURCES; k++) begin
      if (grant_oh_q[k]) begin
        sel_valid_c = i_tvalid[k];
        sel_last_c  = i_tlast[k];
        sel_data_c  = i_tdata[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Next-state, grant and output-slice update.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    grant_oh_d = grant_oh_q;
    tvalid_d   = tvalid_q;
    tlast_d    = tlast_q;
    tdata_d    = tdata_q;
    o_tready   = '0;

    if (tvalid_q && i_tready) begin
      tvalid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (any_req_c) begin
          state_d    = STREAM;
          grant_d    = pick_idx_c;
          grant_oh_d = pick_oh_c;
        end
      end
      STREAM: begin
        o_tready = grant_oh_q & {NUM_SOURCES{slice_free_c}};
        if (sel_valid_c && slice_free_c) begin
          tvalid_d = 1'b1;
          tlast_d  = sel_last_c;
          tdata_d  = sel_data_c;
          if (sel_last_c) begin
            state_d = IDLE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q                 <= IDLE;
      grant_q                 <= IDX_W'(NUM_SOURCES - 1);
      grant_oh_q              <= '0;
      grant_oh_q[NUM_SOURCES-1] <= 1'b1;
      tvalid_q                <= 1'b0;
      tlast_q                 <= 1'b0;
      tdata_q                 <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      grant_oh_q <= grant_oh_d;
      tvalid_q   <= tvalid_d;
      tlast_q    <= tlast_d;
      tdata_q    <= tdata_d;
    end
  end

  assign o_tdata  = tdata_q;
  assign o_tlast  = tlast_q;
  assign o_tvalid = tvalid_q;
  assign o_grant  = grant_q;
  assign o_busy   = (state_q == STREAM);

endmodule
